// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, requester ids and bus size codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } requester_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,         // bit 0 = IFU, bit 1 = LSU
    input  logic       last_grant,  // requester_t encoding
    output logic       gnt_valid,
    output logic       gnt          // requester_t encoding
);

    always_comb begin
        gnt_valid = |req;
        gnt       = REQ_IFU;
        unique case (req)
            2'b01:   gnt = REQ_IFU;
            2'b10:   gnt = REQ_LSU;
            2'b11:   gnt = ~last_grant;
            default: gnt = REQ_IFU;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges IFU and LSU request ports onto one memory bus, one transaction at a time, with a response timeout.
// Handshake: mem_* fields are held stable while mem_reqValid is high; a beat transfers on the rising edge where mem_reqValid && mem_reqReady.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_reqValid,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_respValid,
    output logic [31:0]       ifu_rdata,
    input  logic              lsu_reqValid,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_wen,
    input  logic [31:0]       lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_respValid,
    output logic [31:0]       lsu_rdata,
    output logic              mem_reqValid,
    input  logic              mem_reqReady,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_respValid,
    input  logic              mem_respErr,
    input  logic [31:0]       mem_rdata,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       state, next_state;
    requester_t       grant, last_grant;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid, arb_gnt;
    logic             load_req, resp_take, timeout_take;

    rr_arb2 u_rr_arb2 (
        .req        ({lsu_reqValid, ifu_reqValid}),
        .last_grant (last_grant),
        .gnt_valid  (arb_valid),
        .gnt        (arb_gnt)
    );

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (arb_valid) next_state = SEND;
            SEND:      if (mem_reqReady) next_state = WAIT_RESP;
            WAIT_RESP: if (mem_respValid || cnt >= CNT_LAST) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // A real response in the timeout cycle takes priority over the forced error.
    always_comb begin
        load_req     = 1'b0;
        resp_take    = 1'b0;
        timeout_take = 1'b0;
        mem_reqValid = 1'b0;
        unique case (state)
            IDLE:      load_req = arb_valid;
            SEND:      mem_reqValid = 1'b1;
            WAIT_RESP: begin
                resp_take    = mem_respValid;
                timeout_take = !mem_respValid && (cnt >= CNT_LAST);
            end
            default:   ;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            grant         <= REQ_IFU;
            last_grant    <= REQ_LSU;
            cnt           <= '0;
            mem_addr      <= '0;
            mem_size      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_respValid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_respValid <= 1'b0;
            lsu_rdata     <= '0;
            bus_err       <= 1'b0;
        end else begin
            ifu_respValid <= 1'b0;
            lsu_respValid <= 1'b0;
            bus_err       <= 1'b0;

            if (load_req) begin
                grant <= requester_t'(arb_gnt);
                if (requester_t'(arb_gnt) == REQ_IFU) begin
                    mem_addr  <= ifu_addr;
                    mem_size  <= SIZE_W;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                end else begin
                    mem_addr  <= lsu_addr;
                    mem_size  <= lsu_size;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                end
            end

            if (state == SEND && mem_reqReady)
                cnt <= '0;
            else if (state == WAIT_RESP && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (resp_take || timeout_take) begin
                last_grant <= grant;
                bus_err    <= resp_take ? mem_respErr : 1'b1;
                if (grant == REQ_IFU) begin
                    ifu_respValid <= 1'b1;
                    ifu_rdata     <= resp_take ? mem_rdata : 32'h0;
                end else begin
                    lsu_respValid <= 1'b1;
                    lsu_rdata     <= resp_take ? mem_rdata : 32'h0;
                end
            end
        end
    end

endmodule
